// File: rtl/ctrl_fsm_smac_pkg.sv
// Shared types for the SMAC control FSM.
// State encoding and watchdog default.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG,
    WLOAD,
    ACC1,
    ACC2,
    ACC3,
    QUANT,
    WB,
    VEND,
    VCHK,
    FIN
  } ctrl_state_t;

  localparam int QTO_DEF = 64;

endpackage

// File: rtl/ctrl_fsm_smac_if.sv
// Status flags in, counter strobes out,
// between the SMAC control FSM and its counter top.
interface ctrl_fsm_smac_if;

  logic start;
  logic wt_valid;
  logic act_valid;
  logic wb_ready;
  logic cnt_sr_w7;
  logic bit_m;
  logic term_ac1;
  logic term_ac2;
  logic last_fil;
  logic remW;
  logic done_quant;
  logic relu_done;
  logic op_done;

  logic cnt_load;
  logic cnt_clear_start;
  logic cnt_clear_finish;
  logic cnt_clear_vol;
  logic wei_load;
  logic w_en_w;
  logic w_and_s_ac1;
  logic valid_ac2;
  logic valid_ac3;
  logic act_wb;
  logic cnt_in_vol;
  logic busy;
  logic done;
  logic err;

  modport master (
    output start, wt_valid, act_valid, wb_ready,
    output cnt_sr_w7, bit_m, term_ac1, term_ac2,
    output last_fil, remW, done_quant,
    output relu_done, op_done,
    input  cnt_load, cnt_clear_start,
    input  cnt_clear_finish, cnt_clear_vol,
    input  wei_load, w_en_w, w_and_s_ac1,
    input  valid_ac2, valid_ac3, act_wb,
    input  cnt_in_vol, busy, done, err
  );

  modport slave (
    input  start, wt_valid, act_valid, wb_ready,
    input  cnt_sr_w7, bit_m, term_ac1, term_ac2,
    input  last_fil, remW, done_quant,
    input  relu_done, op_done,
    output cnt_load, cnt_clear_start,
    output cnt_clear_finish, cnt_clear_vol,
    output wei_load, w_en_w, w_and_s_ac1,
    output valid_ac2, valid_ac3, act_wb,
    output cnt_in_vol, busy, done, err
  );

endinterface

// File: rtl/ctrl_fsm_smac.sv
// SMAC main control FSM: weight load, bit-serial MAC,
// quantization with watchdog, write-back, volume bookkeeping.
module ctrl_fsm_smac
  import ctrl_pkg::*;
#(
  parameter int Pw  = 4,
  parameter int Pa  = 8,
  parameter int QTO = QTO_DEF
) (
  input logic            clk,
  input logic            rst,
  ctrl_fsm_smac_if.slave bus
);

  localparam int WDW = $clog2(QTO + 1);
  localparam logic [WDW-1:0] WD_TO  = WDW'(QTO - 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(QTO);
  localparam int unused_prec = Pw + Pa;

  ctrl_state_t    state;
  ctrl_state_t    state_nx;
  logic [WDW-1:0] wd;
  logic           err_q;
  logic           wd_to;
  logic           unused_flags;

  // remW and bit_m only gate the counters
  assign unused_flags = ^{bus.bit_m, bus.remW};

  assign wd_to = (state == QUANT) && !bus.done_quant
               && (wd == WD_TO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state != QUANT)
        wd <= '0;
      else if (wd != WD_MAX)
        wd <= wd + WDW'(1);
      if (state == IDLE && bus.start)
        err_q <= 1'b0;
      else if (wd_to)
        err_q <= 1'b1;
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == FIN);
  assign bus.err  = err_q;

  always_comb begin
    state_nx             = state;
    bus.cnt_load         = 1'b0;
    bus.cnt_clear_start  = 1'b0;
    bus.cnt_clear_finish = 1'b0;
    bus.cnt_clear_vol    = 1'b0;
    bus.wei_load         = 1'b0;
    bus.w_en_w           = 1'b0;
    bus.w_and_s_ac1      = 1'b0;
    bus.valid_ac2        = 1'b0;
    bus.valid_ac3        = 1'b0;
    bus.act_wb           = 1'b0;
    bus.cnt_in_vol       = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_nx = CFG;
      CFG: begin
        bus.cnt_load         = 1'b1;
        bus.cnt_clear_start  = 1'b1;
        bus.cnt_clear_finish = 1'b1;
        bus.cnt_clear_vol    = 1'b1;
        state_nx             = WLOAD;
      end
      WLOAD: begin
        bus.wei_load = bus.wt_valid;
        if (bus.wt_valid && bus.cnt_sr_w7)
          state_nx = ACC1;
      end
      ACC1: begin
        bus.w_and_s_ac1 = bus.act_valid;
        if (bus.act_valid && bus.term_ac1)
          state_nx = ACC2;
      end
      ACC2: begin
        bus.valid_ac2 = 1'b1;
        bus.w_en_w    = 1'b1;
        state_nx      = bus.term_ac2 ? ACC3 : ACC1;
      end
      ACC3: begin
        bus.valid_ac3 = 1'b1;
        state_nx      = bus.last_fil ? QUANT : WLOAD;
      end
      QUANT: begin
        if (bus.done_quant)
          state_nx = WB;
        else if (wd_to)
          state_nx = IDLE;
      end
      WB: begin
        bus.act_wb = bus.wb_ready;
        if (bus.wb_ready && bus.relu_done)
          state_nx = VEND;
      end
      VEND: begin
        bus.cnt_in_vol       = 1'b1;
        bus.cnt_clear_finish = 1'b1;
        state_nx             = VCHK;
      end
      VCHK: begin
        if (bus.op_done) begin
          state_nx = FIN;
        end else begin
          bus.cnt_clear_start = 1'b1;
          state_nx            = WLOAD;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule
